// File: rtl/id_fwd_stage_if.sv
// ID-stage bus: instruction/decode inputs, forwarding sources, write-back port,
// and the registered ID/EXE outputs.
interface id_fwd_stage_if #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 3
);
    logic [31:0]       pc4;
    logic [31:0]       inst;
    logic              c_wreg;
    logic              c_m2reg;
    logic              c_wmem;
    logic              c_aluimm;
    logic              c_shift;
    logic              c_regrt;
    logic              c_sext;
    logic [ALUC_W-1:0] c_aluc;
    logic              flush;
    logic [XLEN-1:0]   exe_alu;
    logic              mem_wreg;
    logic [4:0]        mem_rn;
    logic [XLEN-1:0]   mem_data;
    logic              wb_we;
    logic [4:0]        wb_rn;
    logic [XLEN-1:0]   wb_data;
    logic              stall;
    logic              rsrtequ;
    logic [31:0]       bpc;
    logic [31:0]       jpc;
    logic              exe_wreg;
    logic              exe_m2reg;
    logic              exe_wmem;
    logic              exe_aluimm;
    logic              exe_shift;
    logic [ALUC_W-1:0] exe_aluc;
    logic [4:0]        exe_d;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   exe_imm;

    modport slave (
        input  pc4, inst, c_wreg, c_m2reg, c_wmem, c_aluimm, c_shift, c_regrt, c_sext,
               c_aluc, flush, exe_alu, mem_wreg, mem_rn, mem_data, wb_we, wb_rn, wb_data,
        output stall, rsrtequ, bpc, jpc, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm,
               exe_shift, exe_aluc, exe_d, a, b, exe_imm
    );

    modport master (
        output pc4, inst, c_wreg, c_m2reg, c_wmem, c_aluimm, c_shift, c_regrt, c_sext,
               c_aluc, flush, exe_alu, mem_wreg, mem_rn, mem_data, wb_we, wb_rn, wb_data,
        input  stall, rsrtequ, bpc, jpc, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm,
               exe_shift, exe_aluc, exe_d, a, b, exe_imm
    );
endinterface

// File: rtl/id_fwd_stage.sv
// Pipeline ID stage: register file, operand forwarding, hazard stall,
// branch/jump target generation and the ID/EXE pipeline register.
module id_fwd_stage #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1,
    parameter int ALUC_W = 3
) (
    input logic          clk,
    input logic          clrn,
    id_fwd_stage_if.slave bus
);
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      rn;
    logic [15:0]     imm16;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            stall_c;
    logic            bubble;
    logic [XLEN-1:0] regs [32];
    logic            unused_opcode;

    assign rs    = bus.inst[9:5];
    assign rt    = bus.inst[4:0];
    assign rd    = bus.inst[14:10];
    assign imm16 = bus.inst[25:10];
    assign rn    = bus.c_regrt ? rt : rd;
    assign imm   = {{(XLEN-16){bus.c_sext & imm16[15]}}, imm16};

    assign bus.bpc = bus.pc4 + {imm[29:0], 2'b00};
    assign bus.jpc = {bus.pc4[31:28], bus.inst[25:0], 2'b00};

    assign unused_opcode = ^bus.inst[31:26];

    // r0 reads as zero; a same-cycle write-back is bypassed into the read
    assign rf_a = (rs == 5'd0) ? '0 :
                  (bus.wb_we && bus.wb_rn == rs) ? bus.wb_data : regs[rs];
    assign rf_b = (rt == 5'd0) ? '0 :
                  (bus.wb_we && bus.wb_rn == rt) ? bus.wb_data : regs[rt];

    // Register file: cleared by reset, written on write-back (r0 never written)
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && bus.wb_rn != 5'd0) begin
            regs[bus.wb_rn] <= bus.wb_data;
        end
    end

    // Operand selection and hazard detection; EXE result beats MEM result
    always_comb begin
        fwd_a   = rf_a;
        fwd_b   = rf_b;
        stall_c = 1'b0;
        if (FWD_EN != 0) begin
            if (bus.exe_wreg && !bus.exe_m2reg && bus.exe_d == rs && rs != 5'd0) begin
                fwd_a = bus.exe_alu;
            end else if (bus.mem_wreg && bus.mem_rn == rs && rs != 5'd0) begin
                fwd_a = bus.mem_data;
            end
            if (bus.exe_wreg && !bus.exe_m2reg && bus.exe_d == rt && rt != 5'd0) begin
                fwd_b = bus.exe_alu;
            end else if (bus.mem_wreg && bus.mem_rn == rt && rt != 5'd0) begin
                fwd_b = bus.mem_data;
            end
            stall_c = bus.exe_wreg && bus.exe_m2reg && bus.exe_d != 5'd0 &&
                      (bus.exe_d == rs || bus.exe_d == rt);
        end else begin
            stall_c = (rs != 5'd0 && ((bus.exe_wreg && bus.exe_d == rs) ||
                                      (bus.mem_wreg && bus.mem_rn == rs))) ||
                      (rt != 5'd0 && ((bus.exe_wreg && bus.exe_d == rt) ||
                                      (bus.mem_wreg && bus.mem_rn == rt)));
        end
    end

    assign bus.stall   = stall_c;
    assign bus.rsrtequ = (fwd_a == fwd_b);
    assign bubble      = stall_c | bus.flush;

    // ID/EXE pipeline register; a stall or flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.exe_wreg   <= 1'b0;
            bus.exe_m2reg  <= 1'b0;
            bus.exe_wmem   <= 1'b0;
            bus.exe_aluimm <= 1'b0;
            bus.exe_shift  <= 1'b0;
            bus.exe_aluc   <= '0;
            bus.exe_d      <= '0;
            bus.a          <= '0;
            bus.b          <= '0;
            bus.exe_imm    <= '0;
        end else if (bubble) begin
            bus.exe_wreg   <= 1'b0;
            bus.exe_m2reg  <= 1'b0;
            bus.exe_wmem   <= 1'b0;
            bus.exe_aluimm <= 1'b0;
            bus.exe_shift  <= 1'b0;
            bus.exe_aluc   <= '0;
            bus.exe_d      <= '0;
            bus.a          <= '0;
            bus.b          <= '0;
            bus.exe_imm    <= '0;
        end else begin
            bus.exe_wreg   <= bus.c_wreg;
            bus.exe_m2reg  <= bus.c_m2reg;
            bus.exe_wmem   <= bus.c_wmem;
            bus.exe_aluimm <= bus.c_aluimm;
            bus.exe_shift  <= bus.c_shift;
            bus.exe_aluc   <= bus.c_aluc;
            bus.exe_d      <= rn;
            bus.a          <= fwd_a;
            bus.b          <= fwd_b;
            bus.exe_imm    <= imm;
        end
    end
endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: one forwarding instance and one stall-only instance
// sharing the same stimulus; each vector names which instance it checks.
module tb_id_fwd_stage;
    localparam int XLEN   = 32;
    localparam int ALUC_W = 3;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    id_fwd_stage_if #(.XLEN(XLEN), .ALUC_W(ALUC_W)) bus_f ();
    id_fwd_stage_if #(.XLEN(XLEN), .ALUC_W(ALUC_W)) bus_n ();

    id_fwd_stage #(.XLEN(XLEN), .FWD_EN(1), .ALUC_W(ALUC_W)) u_f (
        .clk(clk), .clrn(clrn), .bus(bus_f)
    );
    id_fwd_stage #(.XLEN(XLEN), .FWD_EN(0), .ALUC_W(ALUC_W)) u_n (
        .clk(clk), .clrn(clrn), .bus(bus_n)
    );

    // the stall-only instance sees exactly the same inputs
    assign bus_n.pc4      = bus_f.pc4;
    assign bus_n.inst     = bus_f.inst;
    assign bus_n.c_wreg   = bus_f.c_wreg;
    assign bus_n.c_m2reg  = bus_f.c_m2reg;
    assign bus_n.c_wmem   = bus_f.c_wmem;
    assign bus_n.c_aluimm = bus_f.c_aluimm;
    assign bus_n.c_shift  = bus_f.c_shift;
    assign bus_n.c_regrt  = bus_f.c_regrt;
    assign bus_n.c_sext   = bus_f.c_sext;
    assign bus_n.c_aluc   = bus_f.c_aluc;
    assign bus_n.flush    = bus_f.flush;
    assign bus_n.exe_alu  = bus_f.exe_alu;
    assign bus_n.mem_wreg = bus_f.mem_wreg;
    assign bus_n.mem_rn   = bus_f.mem_rn;
    assign bus_n.mem_data = bus_f.mem_data;
    assign bus_n.wb_we    = bus_f.wb_we;
    assign bus_n.wb_rn    = bus_f.wb_rn;
    assign bus_n.wb_data  = bus_f.wb_data;

    logic        sel_n = 1'b0;
    logic        o_stall, o_eq;
    logic [31:0] o_bpc, o_jpc, o_a, o_b, o_imm;
    logic [12:0] o_ctl;

    assign o_stall = sel_n ? bus_n.stall   : bus_f.stall;
    assign o_eq    = sel_n ? bus_n.rsrtequ : bus_f.rsrtequ;
    assign o_bpc   = sel_n ? bus_n.bpc     : bus_f.bpc;
    assign o_jpc   = sel_n ? bus_n.jpc     : bus_f.jpc;
    assign o_a     = sel_n ? bus_n.a       : bus_f.a;
    assign o_b     = sel_n ? bus_n.b       : bus_f.b;
    assign o_imm   = sel_n ? bus_n.exe_imm : bus_f.exe_imm;
    assign o_ctl   = sel_n ?
        {bus_n.exe_wreg, bus_n.exe_m2reg, bus_n.exe_wmem, bus_n.exe_aluimm, bus_n.exe_shift,
         bus_n.exe_aluc, bus_n.exe_d} :
        {bus_f.exe_wreg, bus_f.exe_m2reg, bus_f.exe_wmem, bus_f.exe_aluimm, bus_f.exe_shift,
         bus_f.exe_aluc, bus_f.exe_d};

    // ctl = {wreg, m2reg, wmem, aluimm, shift, regrt, sext}
    // e_ctl = {wreg, m2reg, wmem, aluimm, shift, aluc[2:0], d[4:0]}
    typedef struct {
        logic        sel;
        logic [31:0] pc4;
        logic [10:0] hi;
        logic [4:0]  rd, rs, rt;
        logic [6:0]  ctl;
        logic [2:0]  aluc;
        logic        flush;
        logic [31:0] exe_alu;
        logic        mem_wreg;
        logic [4:0]  mem_rn;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_rn;
        logic [31:0] wb_data;
        logic        e_stall, e_eq, chk_jpc;
        logic [31:0] e_bpc, e_jpc, e_a, e_b, e_imm;
        logic [12:0] e_ctl;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, imm;
        logic [12:0] ctl;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_in(input logic [31:0] pc4, input logic [10:0] hi,
                                   input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [6:0] ctl,
                                   input logic [2:0] aluc, input logic flush);
        vec_t v;
        v = '{default: '0};
        v.pc4 = pc4; v.hi = hi; v.rd = rd; v.rs = rs; v.rt = rt;
        v.ctl = ctl; v.aluc = aluc; v.flush = flush;
        return v;
    endfunction

    function automatic vec_t mk_exp(input vec_t vi, input logic st, input logic eq,
                                    input logic [31:0] bpc, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] imm,
                                    input logic [12:0] ctl);
        vec_t v;
        v = vi;
        v.e_stall = st; v.e_eq = eq; v.e_bpc = bpc;
        v.e_a = a; v.e_b = b; v.e_imm = imm; v.e_ctl = ctl;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus_f.pc4      = v.pc4;
        bus_f.inst     = {6'h2B, v.hi, v.rd, v.rs, v.rt};
        bus_f.c_wreg   = v.ctl[6];
        bus_f.c_m2reg  = v.ctl[5];
        bus_f.c_wmem   = v.ctl[4];
        bus_f.c_aluimm = v.ctl[3];
        bus_f.c_shift  = v.ctl[2];
        bus_f.c_regrt  = v.ctl[1];
        bus_f.c_sext   = v.ctl[0];
        bus_f.c_aluc   = v.aluc;
        bus_f.flush    = v.flush;
        bus_f.exe_alu  = v.exe_alu;
        bus_f.mem_wreg = v.mem_wreg;
        bus_f.mem_rn   = v.mem_rn;
        bus_f.mem_data = v.mem_data;
        bus_f.wb_we    = v.wb_we;
        bus_f.wb_rn    = v.wb_rn;
        bus_f.wb_data  = v.wb_data;
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        sel_n = v.sel;
        drive(v);
        #2;
        chk({name, ".stall"}, 64'(o_stall), 64'(v.e_stall));
        chk({name, ".rsrtequ"}, 64'(o_eq), 64'(v.e_eq));
        chk({name, ".bpc"}, 64'(o_bpc), 64'(v.e_bpc));
        if (v.chk_jpc) chk({name, ".jpc"}, 64'(o_jpc), 64'(v.e_jpc));
        e.a = v.e_a; e.b = v.e_b; e.imm = v.e_imm; e.ctl = v.e_ctl; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".a"}, 64'(o_a), 64'(e.a));
        chk({e.name, ".b"}, 64'(o_b), 64'(e.b));
        chk({e.name, ".imm"}, 64'(o_imm), 64'(e.imm));
        chk({e.name, ".ctl"}, 64'(o_ctl), 64'(e.ctl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        vec_t v;

        // forwarding-instance table; applied in order so each row sees the previous row in EXE
        tbl[0] = mk_in(32'h1000, 11'h0, 5'd9, 5'd1, 5'd2, 7'b1000000, 3'd2, 1'b0);
        tbl[0] = mk_exp(tbl[0], 0, 0, 32'h1024, 32'h101, 32'h102, 32'h9, {5'b10000, 3'd2, 5'd9});
        tbl[1] = mk_in(32'h100, 11'h7FF, 5'h1F, 5'd3, 5'd10, 7'b1001011, 3'd1, 1'b0);
        tbl[1] = mk_exp(tbl[1], 0, 0, 32'hFC, 32'h103, 32'h0, 32'hFFFFFFFF, {5'b10010, 3'd1, 5'd10});
        tbl[2] = mk_in(32'h2000, 11'h0, 5'd0, 5'd10, 5'd9, 7'b0000100, 3'd5, 1'b0);
        tbl[2].exe_alu = 32'h4444; tbl[2].mem_wreg = 1; tbl[2].mem_rn = 5'd9; tbl[2].mem_data = 32'h9999;
        tbl[2] = mk_exp(tbl[2], 0, 0, 32'h2000, 32'h4444, 32'h9999, 32'h0, {5'b00001, 3'd5, 5'd0});
        tbl[3] = mk_in(32'h3000, 11'h0, 5'd0, 5'd3, 5'd3, 7'b1101010, 3'd0, 1'b0);
        tbl[3].wb_we = 1; tbl[3].wb_rn = 5'd3; tbl[3].wb_data = 32'h55;
        tbl[3] = mk_exp(tbl[3], 0, 1, 32'h3000, 32'h55, 32'h55, 32'h0, {5'b11010, 3'd0, 5'd3});
        tbl[4] = mk_in(32'h4000, 11'h0, 5'd7, 5'd1, 5'd3, 7'b1000000, 3'd7, 1'b0);
        tbl[4] = mk_exp(tbl[4], 1, 0, 32'h401C, 32'h0, 32'h0, 32'h0, 13'h0);
        tbl[5] = mk_in(32'h4000, 11'h0, 5'd7, 5'd1, 5'd3, 7'b1000000, 3'd7, 1'b0);
        tbl[5].mem_wreg = 1; tbl[5].mem_rn = 5'd3; tbl[5].mem_data = 32'h7777;
        tbl[5] = mk_exp(tbl[5], 0, 0, 32'h401C, 32'h101, 32'h7777, 32'h7, {5'b10000, 3'd7, 5'd7});
        tbl[6] = mk_in(32'h5000, 11'h0, 5'd5, 5'd7, 5'd0, 7'b1010000, 3'd4, 1'b1);
        tbl[6].exe_alu = 32'hAAAA;
        tbl[6] = mk_exp(tbl[6], 0, 0, 32'h5014, 32'h0, 32'h0, 32'h0, 13'h0);
        tbl[7] = mk_in(32'h100, 11'h7FF, 5'h1F, 5'd1, 5'd2, 7'b0010001, 3'd6, 1'b0);
        tbl[7].mem_wreg = 1; tbl[7].mem_rn = 5'd2; tbl[7].mem_data = 32'h101;
        tbl[7] = mk_exp(tbl[7], 0, 1, 32'hFC, 32'h101, 32'h101, 32'hFFFFFFFF, {5'b00100, 3'd6, 5'd31});

        // reset state, checked before any clock edge
        clrn = 1'b0;
        drive(mk_in(32'h0, 11'h0, 5'd0, 5'd0, 5'd0, 7'b0, 3'd0, 1'b0));
        #3;
        chk("rst.stall", 64'(o_stall), 64'h0);
        chk("rst.a", 64'(o_a), 64'h0);
        chk("rst.b", 64'(o_b), 64'h0);
        chk("rst.imm", 64'(o_imm), 64'h0);
        chk("rst.ctl", 64'(o_ctl), 64'h0);
        @(negedge clk);
        clrn = 1'b1;

        // preload r1..r7 = 0x101..0x107 while ID is flushed
        for (int k = 1; k <= 7; k++) begin
            v = mk_in(32'h0, 11'h0, 5'd0, 5'd0, 5'd0, 7'b0, 3'd0, 1'b1);
            v.wb_we = 1; v.wb_rn = 5'(k); v.wb_data = 32'h100 + 32'(k);
            v = mk_exp(v, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 13'h0);
            apply(v, "pre");
        end

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // EXE result beats MEM result for the same register
        v = mk_in(32'h200, 11'h0, 5'd4, 5'd0, 5'd0, 7'b1000000, 3'd0, 1'b0);
        apply(mk_exp(v, 0, 1, 32'h210, 32'h0, 32'h0, 32'h4, {5'b10000, 3'd0, 5'd4}), "exe_wr4");
        v = mk_in(32'h204, 11'h0, 5'd0, 5'd4, 5'd0, 7'b0, 3'd0, 1'b0);
        v.exe_alu = 32'h1234; v.mem_wreg = 1; v.mem_rn = 5'd4; v.mem_data = 32'h9;
        apply(mk_exp(v, 0, 0, 32'h204, 32'h1234, 32'h0, 32'h0, 13'h0), "exe_wins");

        // writes to r0 in EXE are never forwarded
        v = mk_in(32'h300, 11'h0, 5'd0, 5'd0, 5'd0, 7'b1000000, 3'd0, 1'b0);
        apply(mk_exp(v, 0, 1, 32'h300, 32'h0, 32'h0, 32'h0, {5'b10000, 3'd0, 5'd0}), "exe_wr0");
        v = mk_in(32'h304, 11'h0, 5'd0, 5'd0, 5'd1, 7'b0, 3'd0, 1'b0);
        v.exe_alu = 32'hFFFF;
        apply(mk_exp(v, 0, 0, 32'h304, 32'h0, 32'h101, 32'h0, 13'h0), "r0_guard");

        // load-use stall coinciding with flush, then reissue
        v = mk_in(32'h400, 11'h0, 5'd6, 5'd0, 5'd0, 7'b1100000, 3'd0, 1'b0);
        apply(mk_exp(v, 0, 1, 32'h418, 32'h0, 32'h0, 32'h6, {5'b11000, 3'd0, 5'd6}), "ld_r6");
        v = mk_in(32'h500, 11'h0, 5'd8, 5'd6, 5'd0, 7'b1000000, 3'd0, 1'b1);
        apply(mk_exp(v, 1, 0, 32'h520, 32'h0, 32'h0, 32'h0, 13'h0), "stall_flush");
        v = mk_in(32'h500, 11'h0, 5'd8, 5'd6, 5'd0, 7'b1000000, 3'd0, 1'b0);
        apply(mk_exp(v, 0, 0, 32'h520, 32'h106, 32'h0, 32'h8, {5'b10000, 3'd0, 5'd8}), "reissue");

        // jump target and zero-extended immediate
        v = mk_in(32'hA0000004, 11'h7FF, 5'h1F, 5'h1F, 5'h1F, 7'b0, 3'd0, 1'b0);
        v.chk_jpc = 1; v.e_jpc = 32'hAFFFFFFC;
        apply(mk_exp(v, 0, 1, 32'hA0040000, 32'h0, 32'h0, 32'h0000FFFF, {5'b00000, 3'd0, 5'd31}), "jump");

        // asynchronous reset mid-cycle clears outputs and register file
        v = mk_in(32'h600, 11'h0, 5'd12, 5'd1, 5'd2, 7'b1111100, 3'd3, 1'b0);
        apply(mk_exp(v, 0, 0, 32'h630, 32'h101, 32'h102, 32'hC, {5'b11111, 3'd3, 5'd12}), "pre_rst");
        #2;
        clrn = 1'b0;
        #1;
        chk("mid_rst.a", 64'(o_a), 64'h0);
        chk("mid_rst.b", 64'(o_b), 64'h0);
        chk("mid_rst.imm", 64'(o_imm), 64'h0);
        chk("mid_rst.ctl", 64'(o_ctl), 64'h0);
        chk("mid_rst.stall", 64'(o_stall), 64'h0);
        @(negedge clk);
        clrn = 1'b1;
        v = mk_in(32'h700, 11'h0, 5'd12, 5'd1, 5'd2, 7'b0, 3'd0, 1'b0);
        apply(mk_exp(v, 0, 1, 32'h730, 32'h0, 32'h0, 32'hC, {5'b00000, 3'd0, 5'd12}), "post_rst");

        // stall-only instance: any pending writer of a source stalls, nothing forwarded
        v = mk_in(32'h800, 11'h0, 5'd5, 5'd2, 5'd0, 7'b1000000, 3'd0, 1'b0);
        v.sel = 1; v.mem_wreg = 1; v.mem_rn = 5'd2; v.mem_data = 32'h77;
        v.wb_we = 1; v.wb_rn = 5'd2; v.wb_data = 32'h22;
        apply(mk_exp(v, 1, 0, 32'h814, 32'h0, 32'h0, 32'h0, 13'h0), "nf_mem_stall");
        v = mk_in(32'h800, 11'h0, 5'd5, 5'd2, 5'd0, 7'b1000000, 3'd0, 1'b0);
        v.sel = 1;
        apply(mk_exp(v, 0, 0, 32'h814, 32'h22, 32'h0, 32'h5, {5'b10000, 3'd0, 5'd5}), "nf_issue");
        v = mk_in(32'h900, 11'h0, 5'd0, 5'd0, 5'd5, 7'b0, 3'd0, 1'b0);
        v.sel = 1; v.exe_alu = 32'h999;
        apply(mk_exp(v, 1, 1, 32'h900, 32'h0, 32'h0, 32'h0, 13'h0), "nf_exe_stall");
        v = mk_in(32'h904, 11'h0, 5'd0, 5'd3, 5'd4, 7'b0, 3'd0, 1'b0);
        v.sel = 1; v.mem_rn = 5'd3; v.mem_data = 32'h55;
        apply(mk_exp(v, 0, 1, 32'h904, 32'h0, 32'h0, 32'h0, 13'h0), "nf_no_wreg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
